// File: rtl/cond_pkg.sv
// Shared constants for condition evaluation and flag handling.
package cond_pkg;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam int FLAGW_NZ = 1;
   localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluation against a 4-bit NZCV value.
// Zero latency; no handshake.
module cond_check
   import cond_pkg::*;
(
   input  logic [3:0] cond_i,
   input  logic [3:0] flags_i,
   output logic       condex_o
);

   logic n, z, c, v;

   always_comb begin
      n = flags_i[FLAG_N];
      z = flags_i[FLAG_Z];
      c = flags_i[FLAG_C];
      v = flags_i[FLAG_V];
      condex_o = 1'b0;
      case (cond_i)
         COND_EQ: condex_o = z;
         COND_NE: condex_o = ~z;
         COND_CS: condex_o = c;
         COND_CC: condex_o = ~c;
         COND_MI: condex_o = n;
         COND_PL: condex_o = ~n;
         COND_VS: condex_o = v;
         COND_VC: condex_o = ~v;
         COND_HI: condex_o = c & ~z;
         COND_LS: condex_o = ~c | z;
         COND_GE: condex_o = (n == v);
         COND_LT: condex_o = (n != v);
         COND_GT: condex_o = ~z & (n == v);
         COND_LE: condex_o = z | (n != v);
         COND_AL: condex_o = 1'b1;
         default: condex_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_logic.sv
// Condition gating of decoder write strobes plus the architectural NZCV register.
// Strobes are combinational; flags/counters update on the clock edge. Stall/bubble suppress all side effects.
// Optional performance counters are built only when COND_PERF_CNT_EN is defined.
module cond_logic
   import cond_pkg::*;
#(
   parameter logic [3:0] RESET_FLAGS = 4'b0000,
   parameter int         CNT_W       = 32
) (
   input  logic             CLK,
   input  logic             RESETn,
   input  logic             Valid,
   input  logic             Stall,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             NoWrite,
   input  logic [1:0]       FlagW,
   input  logic             CntClr,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             CondEx,
   output logic [3:0]       Flags,
   output logic [CNT_W-1:0] ExecCnt,
   output logic [CNT_W-1:0] SquashCnt
);

   logic [3:0] flags_q, flags_d;
   logic       cond_ok;
   logic       issue;
   logic       go;

   // Evaluated on the registered flags only; ALU results never forward.
   cond_check u_cond_check (
      .cond_i   (Cond),
      .flags_i  (flags_q),
      .condex_o (cond_ok)
   );

   assign issue    = Valid & ~Stall;
   assign go       = issue & cond_ok;
   assign CondEx   = cond_ok;
   assign Flags    = flags_q;
   assign PCSrc    = PCS & go;
   assign MemWrite = MemW & go;
   assign RegWrite = RegW & ~NoWrite & go;

   always_comb begin
      flags_d = flags_q;
      if (go && FlagW[FLAGW_NZ]) begin
         flags_d[FLAG_N] = ALUFlags[FLAG_N];
         flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
      end
      if (go && FlagW[FLAGW_CV]) begin
         flags_d[FLAG_C] = ALUFlags[FLAG_C];
         flags_d[FLAG_V] = ALUFlags[FLAG_V];
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) flags_q <= RESET_FLAGS;
      else         flags_q <= flags_d;
   end

`ifdef COND_PERF_CNT_EN
   logic [CNT_W-1:0] exec_q, exec_d;
   logic [CNT_W-1:0] squash_q, squash_d;

   // Clear wins over a same-cycle increment.
   always_comb begin
      exec_d   = exec_q;
      squash_d = squash_q;
      if (CntClr) begin
         exec_d   = '0;
         squash_d = '0;
      end else begin
         if (go)               exec_d   = exec_q + CNT_W'(1);
         if (issue && !cond_ok) squash_d = squash_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         exec_q   <= '0;
         squash_q <= '0;
      end else begin
         exec_q   <= exec_d;
         squash_q <= squash_d;
      end
   end

   assign ExecCnt   = exec_q;
   assign SquashCnt = squash_q;
`else
   logic unused_cntclr;

   assign unused_cntclr = CntClr;
   assign ExecCnt       = '0;
   assign SquashCnt     = '0;
`endif

endmodule
